// File: rtl/curve448_pkg.sv
// ---------------------------------------------------------------------------
// curve448_pkg
// Shared constants and types for the Curve448 field arithmetic blocks.
//   FIELD_W   : field element width (448 bits)
//   P         : field prime 2^448 - 2^224 - 1
//   P_MINUS_2 : fixed inversion exponent used by fermat_inv448
//   state_e   : inversion sequencer states
//   phase_e   : which multiplier operation is in flight (square or multiply)
// ---------------------------------------------------------------------------
package curve448_pkg;

    localparam int FIELD_W = 448;
    localparam int IDX_W   = 9;

    // p = 2^448 - 2^224 - 1: ones everywhere except bit 224.
    localparam logic [FIELD_W-1:0] P         = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [FIELD_W-1:0] P_MINUS_2 = P - 448'd2;

    // Bit 447 of the exponent is absorbed by acc = iZ, so scanning starts at 446.
    localparam logic [IDX_W-1:0] TOP_IDX = 9'd446;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DONE
    } state_e;

    typedef enum logic {
        PH_SQR,
        PH_MUL
    } phase_e;

endpackage

// File: rtl/speed_mult_red.sv
// ---------------------------------------------------------------------------
// speed_mult_red
// 448-bit modular multiplier over p = 2^448 - 2^224 - 1, four pipeline stages:
// full product, two Solinas folds (2^448 == 2^224 + 1 mod p), final
// conditional subtract. Operands must be held while enable is high.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high clear of the control path
//   enable : run the op; drop for at least one cycle between ops
//   iX, iY : canonical operands (< p)
//   ready  : registered, high after the 4th consecutive enabled edge
//   oO     : registered canonical result iX*iY mod p
// ---------------------------------------------------------------------------
module speed_mult_red
    import curve448_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [FIELD_W-1:0] iX,
    input  logic [FIELD_W-1:0] iY,
    output logic               ready,
    output logic [FIELD_W-1:0] oO
);

    logic [2*FIELD_W-1:0] prod_q;
    logic [673:0]         fold1_q;
    logic [448:0]         fold2_q;
    logic [1:0]           cnt_q;

    logic [2*FIELD_W-1:0] prod_d;
    logic [673:0]         fold1_d;
    logic [450:0]         fold_mid;
    logic [448:0]         fold2_d;
    logic [448:0]         diff;
    logic [FIELD_W-1:0]   oO_d;

    assign prod_d = {448'b0, iX} * {448'b0, iY};

    // First fold: lo + hi + hi*2^224, result below 2^674.
    assign fold1_d = {226'b0, prod_q[447:0]}
                   + {226'b0, prod_q[895:448]}
                   + {2'b0, prod_q[895:448], 224'b0};

    // Second and third folds: bring the value below 2^448 + 2^228 < 2p.
    assign fold_mid = {3'b0, fold1_q[447:0]}
                    + {225'b0, fold1_q[673:448]}
                    + {1'b0, fold1_q[673:448], 224'b0};

    assign fold2_d = {1'b0, fold_mid[447:0]}
                   + {446'b0, fold_mid[450:448]}
                   + {222'b0, fold_mid[450:448], 224'b0};

    // One conditional subtract suffices since fold2_q < 2p.
    assign diff = fold2_q - {1'b0, P};
    assign oO_d = diff[448] ? fold2_q[447:0] : diff[447:0];

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_q <= '0;
            ready <= 1'b0;
        end else begin
            if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
            ready <= (cnt_q == 2'd3);
        end
    end

    // NOTE: pipeline data registers carry no reset; ready alone qualifies
    // them, so clearing 2k bits of flops would buy nothing.
    always_ff @(posedge clk) begin
        if (enable) begin
            prod_q  <= prod_d;
            fold1_q <= fold1_d;
            fold2_q <= fold2_d;
            oO      <= oO_d;
        end
    end

endmodule

// File: rtl/fermat_inv448.sv
// ---------------------------------------------------------------------------
// fermat_inv448
// Field inverse iZ^(p-2) mod p by left-to-right square-and-multiply, driving
// one speed_mult_red. 892 multiplier ops of 6 cycles each.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; aborts any op and clears outputs
//   start : request, sampled only in IDLE
//   iZ    : canonical operand, captured when start is accepted
//   busy  : high from start accept until DONE is entered
//   ready : one-cycle pulse, oInv valid
//   oInv  : canonical result, held until overwritten by the next op
// ---------------------------------------------------------------------------
module fermat_inv448
    import curve448_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FIELD_W-1:0] iZ,
    output logic               busy,
    output logic               ready,
    output logic [FIELD_W-1:0] oInv
);

    state_e             state_q;
    phase_e             phase_q;
    logic [FIELD_W-1:0] acc_q;
    logic [FIELD_W-1:0] zreg_q;
    logic [IDX_W-1:0]   idx_q;

    logic               mult_en;
    logic               mult_ready;
    logic [FIELD_W-1:0] mult_y;
    logic [FIELD_W-1:0] mult_o;

    // Operands only change outside RUN, so they are stable for the whole op.
    assign mult_en = (state_q == ST_RUN);
    assign mult_y  = (phase_q == PH_MUL) ? zreg_q : acc_q;

    speed_mult_red u_mult (
        .clk    (clk),
        .reset  (~reset),
        .enable (mult_en),
        .iX     (acc_q),
        .iY     (mult_y),
        .ready  (mult_ready),
        .oO     (mult_o)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_SQR;
            acc_q   <= '0;
            zreg_q  <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            oInv    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q   <= iZ;
                        zreg_q  <= iZ;
                        idx_q   <= TOP_IDX;
                        phase_q <= PH_SQR;
                        busy    <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mult_ready) begin
                        acc_q   <= mult_o;
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // Multiplier enable is low here, which clears it for the next op.
                    if (phase_q == PH_SQR && P_MINUS_2[idx_q]) begin
                        phase_q <= PH_MUL;
                        state_q <= ST_RUN;
                    end else begin
                        phase_q <= PH_SQR;
                        if (idx_q == '0) begin
                            oInv    <= acc_q;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q - 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    ready   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
